zap_shifter_pipe: RTL and testbench

ZAP_SHIFTER_PIPE -- requirements
Module: zap_shifter_pipe

---
 rtl/zap_shifter_pipe_if.sv | 28 ++
 rtl/zap_shifter_pipe.sv | 205 ++++++++++++++++++++
 tb/tb_zap_shifter_pipe.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/zap_shifter_pipe_if.sv
// Request/result handshake bundle for zap_shifter_pipe.
// The slave side is the shifter; the master side issues requests and consumes results.
interface zap_shifter_pipe_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  i_valid;
  logic                  o_ready;
  logic [DATA_WIDTH-1:0] i_source;
  logic [7:0]            i_amount;
  logic                  i_carry;
  logic [2:0]            i_op;
  logic                  i_flush;
  logic                  o_valid;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] o_result;
  logic                  o_carry;
  logic                  o_sat;

  modport master (
    output i_valid, i_source, i_amount, i_carry, i_op, i_flush, i_ready,
    input  o_ready, o_valid, o_result, o_carry, o_sat
  );

  modport slave (
    input  i_valid, i_source, i_amount, i_carry, i_op, i_flush, i_ready,
    output o_ready, o_valid, o_result, o_carry, o_sat
  );
endinterface

// File: rtl/zap_shifter_pipe.sv
// Pipelined barrel shifter: log2(W) mux levels spread over STAGES registers,
// with ARM-style carry out and a saturating shift-left-by-one.
module zap_shifter_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES     = 2
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  zap_shifter_pipe_if.slave bus
);
  localparam int           W     = DATA_WIDTH;
  localparam int           L     = $clog2(DATA_WIDTH);
  localparam int           BASE  = L / STAGES;
  localparam logic [7:0]   W8    = 8'(DATA_WIDTH);
  localparam logic [L-1:0] ONE_L = L'(1);

  localparam logic [2:0] OP_LSL     = 3'd0;
  localparam logic [2:0] OP_LSR     = 3'd1;
  localparam logic [2:0] OP_ASR     = 3'd2;
  localparam logic [2:0] OP_ROR     = 3'd3;
  localparam logic [2:0] OP_RORI    = 3'd4;
  localparam logic [2:0] OP_RRC     = 3'd5;
  localparam logic [2:0] OP_LSL_SAT = 3'd6;

  // Index gi of each array is the input of stage gi; index STAGES is the output.
  logic         valid_in [STAGES+1];
  logic         carry_in [STAGES+1];
  logic         sat_in   [STAGES+1];
  logic [W-1:0] data_in  [STAGES+1];
  logic [2:0]   op_in    [STAGES];
  logic [L-1:0] amt_in   [STAGES];
  logic         msb_in   [STAGES];

  logic advance;
  logic accept;

  assign advance     = !valid_in[STAGES] || bus.i_ready;
  assign bus.o_ready = advance && !bus.i_flush;
  assign accept      = bus.i_valid && bus.o_ready;

  logic [W-1:0] src;
  logic [L-1:0] nm;
  logic [L-1:0] neg_nm;
  logic [L-1:0] nm_m1;
  logic         amt_zero;
  logic         amt_lt_w;
  logic         amt_eq_w;

  assign src      = bus.i_source;
  assign nm       = bus.i_amount[L-1:0];
  assign neg_nm   = ~nm + ONE_L;
  assign nm_m1    = nm - ONE_L;
  assign amt_zero = (bus.i_amount == 8'd0);
  assign amt_lt_w = (bus.i_amount < W8);
  assign amt_eq_w = (bus.i_amount == W8);

  logic [W-1:0] ent_data;
  logic [L-1:0] ent_amt;
  logic         ent_carry;
  logic         ent_msb;
  logic         ent_sat;

  // Out-of-range amounts are folded into the operand here so the shift network
  // only ever sees an in-range distance; ROR/RORI carry comes from the final MSB.
  always_comb begin
    ent_data  = src;
    ent_amt   = nm;
    ent_carry = bus.i_carry;
    ent_msb   = 1'b0;
    ent_sat   = 1'b0;
    case (bus.i_op)
      OP_LSL, OP_LSR: begin
        if (!amt_zero && amt_lt_w) begin
          ent_carry = (bus.i_op == OP_LSL) ? src[neg_nm] : src[nm_m1];
        end else if (!amt_zero) begin
          ent_data  = '0;
          ent_amt   = '0;
          ent_carry = amt_eq_w && ((bus.i_op == OP_LSL) ? src[0] : src[W-1]);
        end
      end
      OP_ASR: begin
        if (!amt_zero && amt_lt_w) begin
          ent_carry = src[nm_m1];
        end else if (!amt_zero) begin
          ent_amt   = '1;
          ent_carry = src[W-1];
        end
      end
      OP_ROR, OP_RORI: ent_msb = !amt_zero;
      OP_RRC: begin
        ent_data  = {src[W-1:1], bus.i_carry};
        ent_amt   = ONE_L;
        ent_carry = src[0];
      end
      OP_LSL_SAT: begin
        ent_amt   = ONE_L;
        ent_carry = src[W-1];
        if (src[W-1] != src[W-2]) begin
          ent_sat  = 1'b1;
          ent_amt  = '0;
          ent_data = {src[W-1], {(W-1){!src[W-1]}}};
        end
      end
      default: begin
        ent_amt   = '0;
        ent_carry = 1'b0;
      end
    endcase
  end

  assign valid_in[0] = accept;
  assign carry_in[0] = ent_carry;
  assign sat_in[0]   = ent_sat;
  assign data_in[0]  = ent_data;
  assign op_in[0]    = bus.i_op;
  assign amt_in[0]   = ent_amt;
  assign msb_in[0]   = ent_msb;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LO = gi * BASE;
    localparam int HI = (gi == STAGES - 1) ? L : (gi + 1) * BASE;

    logic [W-1:0] data_d;
    logic         carry_d;
    logic         valid_q;
    logic         carry_q;
    logic         sat_q;
    logic [W-1:0] data_q;

    always_comb begin
      data_d = data_in[gi];
      for (int j = LO; j < HI; j++) begin
        if (amt_in[gi][j]) begin
          case (op_in[gi])
            OP_LSL, OP_LSL_SAT: data_d = data_d << (1 << j);
            OP_LSR:             data_d = data_d >> (1 << j);
            OP_ASR:             data_d = $signed(data_d) >>> (1 << j);
            default:            data_d = (data_d >> (1 << j)) | (data_d << (W - (1 << j)));
          endcase
        end
      end
    end

    if (gi == STAGES - 1) begin : g_carry
      assign carry_d = msb_in[gi] ? data_d[W-1] : carry_in[gi];
    end else begin : g_carry
      assign carry_d = carry_in[gi];
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sat_q   <= 1'b0;
        data_q  <= '0;
      end else begin
        if (advance) begin
          valid_q <= valid_in[gi];
          carry_q <= carry_d;
          sat_q   <= sat_in[gi];
          data_q  <= data_d;
        end
        if (bus.i_flush) begin
          valid_q <= 1'b0;
        end
      end
    end

    assign valid_in[gi+1] = valid_q;
    assign carry_in[gi+1] = carry_q;
    assign sat_in[gi+1]   = sat_q;
    assign data_in[gi+1]  = data_q;

    if (gi < STAGES - 1) begin : g_ctl
      logic [2:0]   op_q;
      logic [L-1:0] amt_q;
      logic         msb_q;

      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          op_q  <= '0;
          amt_q <= '0;
          msb_q <= 1'b0;
        end else if (advance) begin
          op_q  <= op_in[gi];
          amt_q <= amt_in[gi];
          msb_q <= msb_in[gi];
        end
      end

      assign op_in[gi+1]  = op_q;
      assign amt_in[gi+1] = amt_q;
      assign msb_in[gi+1] = msb_q;
    end
  end

  // Distance bits already consumed by earlier stages are not looked at again.
  logic unused_amt_bits;
  assign unused_amt_bits = ^amt_in[STAGES-1];

  assign bus.o_valid  = valid_in[STAGES];
  assign bus.o_result = data_in[STAGES];
  assign bus.o_carry  = carry_in[STAGES];
  assign bus.o_sat    = sat_in[STAGES];
endmodule

// File: tb/tb_zap_shifter_pipe.sv
// Self-checking bench for zap_shifter_pipe (W=32, STAGES=2): directed corner cases,
// backpressure, flush and reset, plus randomized traffic against a reference model.
module tb_zap_shifter_pipe;
  localparam int W      = 32;
  localparam int STAGES = 2;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         s;
    logic         chk_c;
    int           acc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_xfer   = 0;
  bit chk_lat  = 1'b0;
  bit hold_pend = 1'b0;
  logic [W-1:0] hold_res;
  logic         hold_c;
  logic         hold_s;
  exp_t sb[$];

  zap_shifter_pipe_if #(.DATA_WIDTH(W)) bus ();

  zap_shifter_pipe #(.DATA_WIDTH(W), .STAGES(STAGES)) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [W-1:0] rot_r(input logic [W-1:0] v, input int k);
    if (k == 0) return v;
    return (v >> k) | (v << (W - k));
  endfunction

  // Behavioural reference: result/carry/sat straight from the operation rules.
  function automatic exp_t model(input logic [W-1:0] src, input int n, input logic cin, input int op);
    exp_t e;
    e.res = src; e.c = cin; e.s = 1'b0; e.chk_c = 1'b1; e.acc = 0;
    case (op)
      0: if (n > 0 && n < W) begin e.res = src << n; e.c = src[W-n]; end
         else if (n == W) begin e.res = '0; e.c = src[0]; end
         else if (n > W) begin e.res = '0; e.c = 1'b0; end
      1: if (n > 0 && n < W) begin e.res = src >> n; e.c = src[n-1]; end
         else if (n == W) begin e.res = '0; e.c = src[W-1]; end
         else if (n > W) begin e.res = '0; e.c = 1'b0; end
      2: if (n > 0 && n < W) begin e.res = $signed(src) >>> n; e.c = src[n-1]; end
         else if (n >= W) begin e.res = {W{src[W-1]}}; e.c = src[W-1]; end
      3: begin
        e.res = rot_r(src, n % W);
        e.c = (n == 0) ? cin : ((n % W == 0) ? src[W-1] : e.res[W-1]);
      end
      4: begin
        e.res = rot_r(src, n % W);
        e.c = (n != 0) ? e.res[W-1] : cin;
      end
      5: begin e.res = {cin, src[W-1:1]}; e.c = src[0]; end
      6: begin
        e.res = src << 1;
        e.chk_c = 1'b0;
        if (e.res[W-1] != src[W-1]) begin
          e.s = 1'b1;
          e.res = src[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
      end
      default: e.c = 1'b0;
    endcase
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, check outputs 1ns later, then take the rising edge.
  task automatic step(input logic v, input logic [W-1:0] src, input logic [7:0] amt,
                      input logic cin, input logic [2:0] op, input logic fl, input logic rdy);
    exp_t e;
    @(negedge clk);
    bus.i_valid  = v;
    bus.i_source = src;
    bus.i_amount = amt;
    bus.i_carry  = cin;
    bus.i_op     = op;
    bus.i_flush  = fl;
    bus.i_ready  = rdy;
    #1;
    if (hold_pend) begin
      check("hold_valid", bus.o_valid, 1'b1);
      check("hold_result", bus.o_result, hold_res);
      check("hold_carry", bus.o_carry, hold_c);
      check("hold_sat", bus.o_sat, hold_s);
    end
    hold_pend = 1'b0;
    check("o_ready", bus.o_ready, (!bus.o_valid || rdy) && !fl);
    if (bus.o_valid && !fl) begin
      if (sb.size() == 0) begin
        check("spurious_valid", bus.o_valid, 1'b0);
      end else if (rdy) begin
        e = sb.pop_front();
        n_xfer++;
        $display("xfer %0d: result=%h carry=%b sat=%b", n_xfer, bus.o_result, bus.o_carry, bus.o_sat);
        check("result", bus.o_result, e.res);
        if (e.chk_c) check("carry", bus.o_carry, e.c);
        check("sat", bus.o_sat, e.s);
        if (chk_lat) check("latency", cyc - e.acc, STAGES);
      end else begin
        hold_pend = 1'b1;
        hold_res  = bus.o_result;
        hold_c    = bus.o_carry;
        hold_s    = bus.o_sat;
      end
    end
    if (v && bus.o_ready) begin
      e = model(src, int'(amt), cin, int'(op));
      e.acc = cyc;
      sb.push_back(e);
    end
    if (fl) sb.delete();
    @(posedge clk);
    cyc++;
  endtask

  task automatic req(input logic [W-1:0] src, input logic [7:0] amt, input logic cin, input logic [2:0] op);
    step(1'b1, src, amt, cin, op, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 8'd0, 1'b0, 3'd0, 1'b0, 1'b1);
  endtask

  // Reset asserted between clock edges so the asynchronous clear is observed directly.
  task automatic do_reset();
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_flush = 1'b0;
    bus.i_ready = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_o_valid", bus.o_valid, 1'b0);
    check("rst_o_result", bus.o_result, '0);
    check("rst_o_carry", bus.o_carry, 1'b0);
    check("rst_o_sat", bus.o_sat, 1'b0);
    check("rst_o_ready", bus.o_ready, 1'b1);
    sb.delete();
    hold_pend = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] pick_amt();
    case ($urandom_range(0, 5))
      0: return 8'd0;
      1: return 8'd1;
      2: return 8'd31;
      3: return 8'd32;
      4: return 8'd33;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    bus.i_valid  = 1'b0;
    bus.i_source = '0;
    bus.i_amount = 8'd0;
    bus.i_carry  = 1'b0;
    bus.i_op     = 3'd0;
    bus.i_flush  = 1'b0;
    bus.i_ready  = 1'b1;

    do_reset();
    idle(2);

    // Directed corner cases, back to back, with exact latency checking.
    chk_lat = 1'b1;
    req(32'h8000_0001, 8'd1,  1'b0, 3'd0);
    req(32'h8000_0000, 8'd40, 1'b0, 3'd2);
    req(32'h8000_0000, 8'd32, 1'b0, 3'd1);
    req(32'h0000_0001, 8'd32, 1'b0, 3'd3);
    req(32'h0000_0001, 8'd0,  1'b1, 3'd3);
    req(32'h4000_0000, 8'd0,  1'b0, 3'd6);
    req(32'hC000_0000, 8'd0,  1'b0, 3'd6);
    req(32'h1234_5678, 8'd0,  1'b1, 3'd0);
    req(32'h1234_5679, 8'd32, 1'b1, 3'd0);
    req(32'hF234_5678, 8'd33, 1'b1, 3'd1);
    req(32'h0F00_00F1, 8'd4,  1'b0, 3'd4);
    req(32'h0F00_00F1, 8'd0,  1'b1, 3'd4);
    req(32'h8000_0003, 8'd9,  1'b1, 3'd5);
    req(32'hDEAD_BEEF, 8'd17, 1'b1, 3'd7);
    req(32'h7000_0000, 8'd31, 1'b0, 3'd2);
    req(32'h8000_0000, 8'd5,  1'b0, 3'd6);
    idle(4);

    // Four requests with the consumer stalling for three cycles on the first result.
    req(32'h0000_0011, 8'd1, 1'b0, 3'd0);
    req(32'h0000_0022, 8'd2, 1'b0, 3'd1);
    chk_lat = 1'b0;
    step(1'b1, 32'h0000_0033, 8'd3, 1'b0, 3'd3, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0033, 8'd3, 1'b0, 3'd3, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0033, 8'd3, 1'b0, 3'd3, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0033, 8'd3, 1'b0, 3'd3, 1'b0, 1'b1);
    req(32'h8000_0044, 8'd4, 1'b1, 3'd2);
    idle(4);
    check("stall_drained", sb.size(), 0);

    // Randomized traffic with backpressure and occasional flushes.
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 9) < 7, $urandom, pick_amt(), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), $urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0);
    end
    idle(4);

    // Flush with two in flight, the oldest already presented at the output.
    req(32'h0000_00A1, 8'd1, 1'b0, 3'd0);
    req(32'h0000_00B2, 8'd1, 1'b0, 3'd0);
    step(1'b0, '0, 8'd0, 1'b0, 3'd0, 1'b1, 1'b1);
    idle(4);

    // Reset asserted with requests still in the pipe.
    req(32'h0000_00C3, 8'd2, 1'b0, 3'd1);
    req(32'h0000_00D4, 8'd2, 1'b0, 3'd1);
    do_reset();
    idle(4);
    chk_lat = 1'b1;
    req(32'h8000_0001, 8'd1, 1'b0, 3'd0);
    idle(3);
    check("final_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
